// File: rtl/present_scheduler_pkg.sv
// Shared types and constants for the PRESENT job scheduler.
// Also provides the wrap-around index helper used by the arbiter and the pointer update.
package present_sched_pkg;

    localparam int KEY_W        = 80;
    localparam int BLK_W        = 64;
    localparam int CORE_ROUNDS  = 31;
    localparam int WATCHDOG_CYC = 40;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        CAPTURE,
        RESP
    } sched_state_t;

    // Callers keep value below 2*modulus, so one subtraction is enough.
    function automatic int wrap_index(input int value, input int modulus);
        return (value >= modulus) ? value - modulus : value;
    endfunction

endpackage

// File: rtl/present_scheduler_if.sv
// Job request and result response bundle between the job sources/consumer and the scheduler.
interface present_scheduler_if
    import present_sched_pkg::*;
#(
    parameter int NUM_REQ = 4
) ();

    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*KEY_W-1:0] req_key;
    logic [NUM_REQ*BLK_W-1:0] req_text;

    logic                     out_valid;
    logic                     out_ready;
    logic [BLK_W-1:0]         out_text;
    logic [ID_W-1:0]          out_id;

    modport master (
        output req_valid, req_key, req_text, out_ready,
        input  req_ready, out_valid, out_text, out_id
    );

    modport slave (
        input  req_valid, req_key, req_text, out_ready,
        output req_ready, out_valid, out_text, out_id
    );

endinterface

// File: rtl/present_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requesting index at or after ptr wins.
module rr_arbiter
    import present_sched_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    logic            found;
    logic [ID_W-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'(wrap_index(int'(ptr) + k, NUM_REQ));
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/present_scheduler.sv
// Shares one iterative PRESENT core among NUM_REQ requesters: round-robin accept,
// Enable/Done sequencing, single-cycle ciphertext capture and a held valid/ready response.
module present_scheduler
    import present_sched_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic               Clock,
    input  logic               Reset,
    present_scheduler_if.slave bus,
    output logic [KEY_W-1:0]   core_key,
    output logic [BLK_W-1:0]   core_plaintext,
    output logic               core_enable,
    input  logic               core_done,
    input  logic [BLK_W-1:0]   core_ciphertext,
    output logic               busy
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam int WD_W = $clog2(WATCHDOG_CYC);

    sched_state_t     state;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  grant_idx;
    logic [NUM_REQ-1:0] grant;
    logic [WD_W-1:0]  wd_cnt;
    logic             wd_expired;
    logic             err_timeout;
    logic             out_valid_q;
    logic [BLK_W-1:0] out_text_q;
    logic [ID_W-1:0]  out_id_q;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req       (bus.req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // The grant is only offered while idle, so the accepting edge is also the IDLE->LOAD edge.
    assign bus.req_ready = (state == IDLE) ? grant : '0;
    assign bus.out_valid = out_valid_q;
    assign bus.out_text  = out_text_q;
    assign bus.out_id    = out_id_q;

    assign wd_expired = (wd_cnt == WD_W'(WATCHDOG_CYC - 1));

    // Enable is low in LOAD so the core reloads plaintext; it stays high through CAPTURE
    // because the core's final key addition happens on the edge that enters CAPTURE.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            core_key       <= '0;
            core_plaintext <= '0;
            core_enable    <= 1'b0;
            out_valid_q    <= 1'b0;
            out_text_q     <= '0;
            out_id_q       <= '0;
            busy           <= 1'b0;
            wd_cnt         <= '0;
            err_timeout    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req_valid) begin
                        core_key       <= bus.req_key[int'(grant_idx)*KEY_W +: KEY_W];
                        core_plaintext <= bus.req_text[int'(grant_idx)*BLK_W +: BLK_W];
                        out_id_q       <= grant_idx;
                        rr_ptr         <= ID_W'(wrap_index(int'(grant_idx) + 1, NUM_REQ));
                        busy           <= 1'b1;
                        state          <= LOAD;
                    end
                end
                LOAD: begin
                    core_enable <= 1'b1;
                    wd_cnt      <= '0;
                    state       <= RUN;
                end
                RUN: begin
                    // A hung core still produces a response; the sticky flag records it.
                    if (core_done || wd_expired) begin
                        err_timeout <= err_timeout | ~core_done;
                        state       <= CAPTURE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                CAPTURE: begin
                    out_text_q  <= core_ciphertext;
                    out_valid_q <= 1'b1;
                    core_enable <= 1'b0;
                    state       <= RESP;
                end
                RESP: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_present_scheduler.sv
// Bench for present_scheduler: behavioural PRESENT core stand-in, block-level PRESENT-80
// reference and a round-robin pointer model drive directed and random jobs.
module tb_present_scheduler;
    import present_sched_pkg::*;

    localparam int NREQ = 4;
    localparam int ID_W = $clog2(NREQ);

    logic             Clock = 1'b0;
    logic             Reset = 1'b1;
    logic [KEY_W-1:0] core_key;
    logic [BLK_W-1:0] core_plaintext;
    logic [BLK_W-1:0] core_ciphertext;
    logic             core_enable;
    logic             core_done;
    logic             busy;

    int total_checks = 0;
    int bad_checks   = 0;
    int cyc          = 0;

    present_scheduler_if #(.NUM_REQ(NREQ)) bus ();

    present_scheduler #(.NUM_REQ(NREQ)) dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .bus             (bus),
        .core_key        (core_key),
        .core_plaintext  (core_plaintext),
        .core_enable     (core_enable),
        .core_done       (core_done),
        .core_ciphertext (core_ciphertext),
        .busy            (busy)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        case (x)
            4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
            4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
            4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
            4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
        endcase
    endfunction

    function automatic logic [63:0] s_layer(input logic [63:0] s);
        logic [63:0] r;
        for (int n = 0; n < 16; n++) r[n*4 +: 4] = sbox4(s[n*4 +: 4]);
        return r;
    endfunction

    function automatic logic [63:0] p_layer(input logic [63:0] s);
        logic [63:0] r;
        r = '0;
        for (int j = 0; j < 63; j++) r[(j*16) % 63] = s[j];
        r[63] = s[63];
        return r;
    endfunction

    function automatic logic [79:0] key_update(input logic [79:0] k, input int rc);
        logic [79:0] r;
        r = {k[18:0], k[79:19]};
        r[79:76] = sbox4(r[79:76]);
        r[19:15] = r[19:15] ^ 5'(rc);
        return r;
    endfunction

    function automatic logic [63:0] present_encrypt(input logic [79:0] key, input logic [63:0] pt);
        logic [63:0] s;
        logic [79:0] k;
        s = pt;
        k = key;
        for (int i = 1; i <= CORE_ROUNDS; i++) begin
            s = p_layer(s_layer(s ^ k[79:16]));
            k = key_update(k, i);
        end
        return s ^ k[79:16];
    endfunction

    // Iterative core stand-in: one round per enabled cycle, Done during the last round
    // cycle, final key addition on the Done edge, then the state is scrambled.
    logic [63:0] c_state = '0;
    logic [79:0] c_key   = '0;
    int          c_round = 0;
    logic        hang_core = 1'b0;

    always @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            c_state <= '0;
            c_key   <= '0;
            c_round <= 0;
        end else if (!core_enable) begin
            c_state <= core_plaintext;
            c_key   <= core_key;
            c_round <= 0;
        end else if (c_round < CORE_ROUNDS) begin
            c_state <= p_layer(s_layer(c_state ^ c_key[79:16]));
            c_key   <= key_update(c_key, c_round + 1);
            c_round <= c_round + 1;
        end else if (c_round == CORE_ROUNDS) begin
            if (!hang_core) begin
                c_state <= c_state ^ c_key[79:16];
                c_round <= c_round + 1;
            end
        end else begin
            c_state <= ~c_state;
        end
    end

    assign core_done       = (c_round == CORE_ROUNDS) && !hang_core;
    assign core_ciphertext = c_state;

    logic             pv  [NREQ];
    logic [KEY_W-1:0] pk  [NREQ];
    logic [BLK_W-1:0] ptx [NREQ];
    int               rr_ptr_model;

    task automatic checkOutput(input string tag, input logic [79:0] got, input logic [79:0] exp);
        total_checks++;
        if (got !== exp) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [79:0] rand_key();
        logic [79:0] r;
        r[31:0]  = $urandom();
        r[63:32] = $urandom();
        r[79:64] = 16'($urandom());
        return r;
    endfunction

    function automatic logic [63:0] rand_text();
        logic [63:0] r;
        r[31:0]  = $urandom();
        r[63:32] = $urandom();
        return r;
    endfunction

    task automatic drive_requests();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_valid[i]               = pv[i];
            bus.req_key[i*KEY_W +: KEY_W]  = pk[i];
            bus.req_text[i*BLK_W +: BLK_W] = ptx[i];
        end
    endtask

    task automatic applyStimulus(input int idx, input logic [79:0] k, input logic [63:0] t);
        pv[idx]  = 1'b1;
        pk[idx]  = k;
        ptx[idx] = t;
        drive_requests();
    endtask

    task automatic drop_request(input int idx);
        pv[idx] = 1'b0;
        drive_requests();
    endtask

    function automatic int expected_winner();
        for (int k = 0; k < NREQ; k++) begin
            if (pv[(rr_ptr_model + k) % NREQ]) return (rr_ptr_model + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic wait_accept(output int winner, output logic [79:0] job_key,
                               output logic [63:0] job_text, output int accept_cyc);
        logic [NREQ-1:0] exp_ready;
        logic            accepted;
        int              w;
        winner     = -1;
        job_key    = '0;
        job_text   = '0;
        accept_cyc = 0;
        accepted   = 1'b0;
        for (int n = 0; n < 200 && !accepted; n++) begin
            @(negedge Clock);
            w = expected_winner();
            if (!busy && w >= 0) begin
                exp_ready    = '0;
                exp_ready[w] = 1'b1;
                checkOutput("req_ready_grant", 80'(bus.req_ready), 80'(exp_ready));
                job_key  = pk[w];
                job_text = ptx[w];
                @(posedge Clock);
                #1;
                accept_cyc   = cyc;
                winner       = w;
                rr_ptr_model = (w + 1) % NREQ;
                drop_request(w);
                checkOutput("load_enable_low", 80'(core_enable), 80'(0));
                checkOutput("busy_after_accept", 80'(busy), 80'(1));
                accepted = 1'b1;
            end
        end
        checkOutput("accept_seen", 80'(accepted), 80'(1));
    endtask

    task automatic wait_result(input int w, input logic [79:0] job_key, input logic [63:0] job_text,
                               input int exp_lat, input bit check_text, input int hold,
                               output logic [63:0] got_text);
        int               cycles;
        logic             seen, key_bad, ready_bad, stable_bad;
        logic [63:0]      ref_text;
        logic [ID_W-1:0]  held_id;
        cycles    = 0;
        seen      = 1'b0;
        key_bad   = 1'b0;
        ready_bad = 1'b0;
        while (!seen && cycles < 100) begin
            @(posedge Clock);
            #1;
            cycles++;
            if (cycles == 1) checkOutput("run_enable_high", 80'(core_enable), 80'(1));
            if (core_key !== job_key || core_plaintext !== job_text) key_bad = 1'b1;
            if (bus.req_ready !== '0) ready_bad = 1'b1;
            seen = bus.out_valid;
        end
        got_text = bus.out_text;
        checkOutput("latency", 80'(cycles), 80'(exp_lat));
        checkOutput("core_key_stable", 80'(key_bad), 80'(0));
        checkOutput("ready_quiet_busy", 80'(ready_bad), 80'(0));
        checkOutput("out_id", 80'(bus.out_id), 80'(w));
        checkOutput("resp_enable_low", 80'(core_enable), 80'(0));
        ref_text = check_text ? present_encrypt(job_key, job_text) : bus.out_text;
        if (check_text) checkOutput("out_text", 80'(bus.out_text), 80'(ref_text));
        if (hold > 0) begin
            bus.out_ready = 1'b0;
            held_id       = ID_W'(w);
            stable_bad    = 1'b0;
            repeat (hold) begin
                @(posedge Clock);
                #1;
                if (bus.out_text !== ref_text || bus.out_id !== held_id || !bus.out_valid ||
                    bus.req_ready !== '0 || core_enable !== 1'b0) stable_bad = 1'b1;
            end
            checkOutput("backpressure_hold", 80'(stable_bad), 80'(0));
            bus.out_ready = 1'b1;
        end
        @(posedge Clock);
        #1;
        checkOutput("handshake_clears", 80'({bus.out_valid, busy}), 80'(0));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation time limit reached");
        $fatal(1, "[TB] stopped");
    end

    initial begin
        int          w, ac, prev_ac;
        logic [79:0] k;
        logic [63:0] t, txt;

        bus.req_valid = '0;
        bus.req_key   = '0;
        bus.req_text  = '0;
        bus.out_ready = 1'b1;
        rr_ptr_model  = 0;
        for (int i = 0; i < NREQ; i++) begin
            pv[i]  = 1'b0;
            pk[i]  = '0;
            ptx[i] = '0;
        end

        #1 Reset = 1'b0;
        repeat (3) @(negedge Clock);
        checkOutput("reset_flags", 80'({bus.out_valid, busy, core_enable, bus.req_ready}), 80'(0));
        checkOutput("reset_out_text", 80'(bus.out_text), 80'(0));
        checkOutput("reset_core_key", core_key, 80'(0));
        Reset = 1'b1;
        $display("[TB] reset released");

        applyStimulus(0, '0, '0);
        wait_accept(w, k, t, ac);
        checkOutput("winner_req0", 80'(w), 80'(0));
        wait_result(w, k, t, 34, 1'b1, 0, txt);
        checkOutput("kat_zero", 80'(txt), 80'(64'h5579C1387B228445));

        applyStimulus(2, '1, '1);
        wait_accept(w, k, t, ac);
        checkOutput("winner_req2", 80'(w), 80'(2));
        wait_result(w, k, t, 34, 1'b1, 20, txt);
        checkOutput("kat_ones", 80'(txt), 80'(64'h3333DCD3213210D2));

        $display("[TB] watchdog job");
        hang_core = 1'b1;
        applyStimulus(3, rand_key(), rand_text());
        wait_accept(w, k, t, ac);
        wait_result(w, k, t, 42, 1'b0, 0, txt);
        checkOutput("err_timeout_set", 80'(dut.err_timeout), 80'(1));
        hang_core = 1'b0;

        $display("[TB] reset during RUN");
        applyStimulus(1, rand_key(), rand_text());
        wait_accept(w, k, t, ac);
        repeat (10) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        checkOutput("midreset_flags", 80'({bus.out_valid, busy, core_enable, bus.req_ready}), 80'(0));
        checkOutput("midreset_core_key", core_key, 80'(0));
        checkOutput("midreset_core_pt", 80'(core_plaintext), 80'(0));
        checkOutput("midreset_out", 80'({bus.out_text, bus.out_id}), 80'(0));
        checkOutput("midreset_err", 80'(dut.err_timeout), 80'(0));
        rr_ptr_model = 0;
        @(negedge Clock);
        Reset = 1'b1;
        applyStimulus(3, rand_key(), rand_text());
        wait_accept(w, k, t, ac);
        checkOutput("winner_after_reset", 80'(w), 80'(3));
        wait_result(w, k, t, 34, 1'b1, 0, txt);

        $display("[TB] all requesters continuously valid");
        for (int i = 0; i < NREQ; i++) applyStimulus(i, rand_key(), rand_text());
        prev_ac = 0;
        for (int j = 0; j < 5; j++) begin
            wait_accept(w, k, t, ac);
            checkOutput("rr_order", 80'(w), 80'(j % NREQ));
            if (w >= 0) applyStimulus(w, rand_key(), rand_text());
            if (j > 0) checkOutput("throughput", 80'(ac - prev_ac), 80'(36));
            prev_ac = ac;
            wait_result(w, k, t, 34, 1'b1, 0, txt);
        end
        for (int i = 0; i < NREQ; i++) drop_request(i);

        $display("[TB] random jobs");
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pv[i] && $urandom_range(0, 1) == 1) applyStimulus(i, rand_key(), rand_text());
                else if (pv[i] && $urandom_range(0, 7) == 0) drop_request(i);
            end
            if (expected_winner() < 0) applyStimulus(int'($urandom_range(0, NREQ - 1)), rand_key(), rand_text());
            wait_accept(w, k, t, ac);
            wait_result(w, k, t, 34, 1'b1, int'($urandom_range(0, 3)), txt);
        end

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule

// File: doc/present_scheduler.md
# present_scheduler

Round-robin scheduler that shares one iterative PRESENT encryption core among `NUM_REQ` requesters. It accepts {key, plaintext} jobs over per-requester valid/ready, registers them, and sequences the core's Enable/Done protocol. It captures the ciphertext in the single cycle it is valid and returns it with the requester ID over a valid/ready response port. It sits between the system-side job sources and the encrypt datapath.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `KEY_W`, 80, key width (matches core key size)
- `BLK_W`, 64, block width (matches core block size)
- `Clock`  in  1  clock
- `Reset`  in  1  reset, asynchronous, active-low; shared with the core
- `req_valid`  in  NUM_REQ  job offered by requester i
- `req_ready`  out  NUM_REQ  job from requester i accepted this cycle
- `req_key`  in  NUM_REQ*KEY_W  packed keys, requester i at [i*KEY_W +: KEY_W]
- `req_text`  in  NUM_REQ*BLK_W  packed plaintexts, same packing
- `core_key`  out  KEY_W  registered key to core; stable for the whole job
- `core_plaintext`  out  BLK_W  registered plaintext to core
- `core_enable`  out  1  core Enable
- `core_done`  in  1  core Done
- `core_ciphertext`  in  BLK_W  core ciphertext
- `out_valid`  out  1  result available
- `out_ready`  in  1  consumer accepts result
- `out_text`  out  BLK_W  ciphertext
- `out_id`  out  $clog2(NUM_REQ)  requester that owns `out_text`
- `busy`  out  1  state != IDLE

## Operation
- FSM states: IDLE, LOAD, RUN, CAPTURE, RESP.
- IDLE: `core_enable`=0. If any `req_valid`, the round-robin arbiter picks the winner starting at `rr_ptr`. Assert `req_ready[winner]` only, combinationally, in this cycle. At the edge, register key, text, and ID; set `rr_ptr` = winner+1 mod NUM_REQ; go to LOAD.
- LOAD: `core_enable`=0 for exactly one cycle. The core loads plaintext and clears its round counter. Next state RUN.
- RUN: `core_enable`=1. Stay until `core_done`=1 is sampled. At that edge the core performs its final key addition; go to CAPTURE.
- CAPTURE: `core_enable`=1. `core_ciphertext` is valid this cycle only. At the edge, register it into `out_text`; go to RESP.
- RESP: `core_enable`=0, `out_valid`=1. `out_text` and `out_id` are held stable. When `out_valid && out_ready`, go to IDLE.
- `req_ready` is 0 in every state except IDLE. At most one bit is set. Requests are never dropped: a valid requester that is not granted keeps waiting.
- Round-robin rule: with all requesters continuously valid, grants cycle 0,1,2,…,NUM_REQ-1,0. Winner = first valid index at or after `rr_ptr`, with wrap-around.
- RUN watchdog: if `core_done` has not been seen 40 cycles after entering RUN, force CAPTURE anyway and set sticky `err_timeout` (internal, readable in sim). The result is still returned.
- Reset (async, any state): FSM=IDLE, `rr_ptr`=0, `req_ready`=0, `core_enable`=0, `out_valid`=0, `out_text`=0, `out_id`=0, `core_key`=0, `core_plaintext`=0, `busy`=0, watchdog=0, `err_timeout`=0. An in-flight job is discarded.

## Timing
- Accept edge = E0. LOAD during E0→E1. RUN from E1; the core's Done asserts after edge E32. Transition to CAPTURE at E33; capture at E34. `out_valid`=1 from E34.
- Fixed latency: 34 cycles from accept edge to `out_valid`.
- With `out_ready` tied high, throughput is one job per 36 cycles: RESP 1 cycle, IDLE 1 cycle.
- Back-pressure: `out_ready`=0 holds RESP indefinitely. No new job is accepted meanwhile.
- `req_valid` deasserting while not granted is legal. Requesters must not change key or text while `req_valid`=1.

## Structure
- Package `present_sched_pkg`:
  - state enum `sched_state_t`
  - `KEY_W`=80, `BLK_W`=64
  - `CORE_ROUNDS`=31
  - `WATCHDOG_CYC`=40
- One sub-module, `rr_arbiter`, parameterised by `NUM_REQ`. Inputs: request vector and pointer. Outputs: one-hot grant and encoded index. Purely combinational.
- The scheduler instantiates `rr_arbiter`; it does not instantiate the core. The core is connected alongside it at the parent level.

## Test plan
- Single job, requester 0: key 0, plaintext 0, `out_ready`=1. `out_valid` at exactly 34 cycles after accept; `out_text`=64'h5579C1387B228445; `out_id`=0.
- Key all-ones, plaintext all-ones, requester 2. `out_text`=64'h3333DCD3213210D2; `out_id`=2; `core_key` stable throughout.
- All 4 requesters valid continuously. Grant order 0,1,2,3,0. Each `req_ready` pulses once per grant; `out_id` sequence matches.
- `out_ready`=0 for 20 cycles in RESP. `out_text` and `out_id` stay stable; no `req_ready` pulses; `core_enable`=0.
- `Reset` asserted in the middle of RUN. All outputs go to their reset values immediately, asynchronously. After release, a new job completes with the correct ciphertext.
- Core model that never raises Done. `err_timeout`=1 and `out_valid` asserted 42 cycles after accept.
